bbox_extract: RTL and testbench
===============================

Name: bbox_extract

Overview:
- Streaming bounding-box extractor; produces the x/y/width/height that feed the box-overlay drawer.
- Consumes a raster-order per-pixel skin/face mask (one bit per pixel) from the detection stage.
- Tracks min/max column and row of set mask pixels over each frame.
- At end of frame emits box centre, full width and full height, with a one-cycle valid pulse.

Parameters:
- IMG_WIDTH, 768, pixels per line.
- IMG_HEIGHT, 576, lines per frame.
- MIN_PIXELS, 64, minimum set-mask pixel count for a box to be reported as found.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  pixel present this cycle; no backpressure, stream never stalls
- in_sof  input  1  start of frame; qualified by in_valid; marks pixel (0,0)
- in_mask  input  1  mask bit of current pixel; 1 = face/skin pixel
- x  output  10  box centre column
- y  output  10  box centre row
- width  output  10  box width in pixels
- height  output  10  box height in pixels
- box_found  output  1  last completed frame met MIN_PIXELS
- box_valid  output  1  one-cycle pulse when x/y/width/height/box_found update

Behaviour:
- Reset:
  - x, y, width, height = 0; box_found = 0; box_valid = 0.
  - Position counters = 0; accumulators cleared; FSM = ACCUM.
- Position counters:
  - col/row advance only on in_valid.
  - col wraps IMG_WIDTH-1 -> 0 and increments row.
  - row wraps IMG_HEIGHT-1 -> 0.
  - in_valid & in_sof forces the current pixel to (0,0); counters continue from there.
- Accumulators:
  - min_x, max_x, min_y, max_y, pix_cnt (20-bit, saturating at 2^20-1), any_set flag.
  - First set pixel of a frame loads min and max with its coordinates.
  - Later set pixels update min/max with compare-and-replace.
- in_sof mid-frame (counters not at (0,0)):
  - Partial frame is discarded; accumulators cleared before the sof pixel is accounted.
  - No box_valid for the aborted frame.
- End of frame = accepted pixel at (IMG_WIDTH-1, IMG_HEIGHT-1):
  - Same edge: accumulators, including that last pixel's contribution, are copied to shadow registers.
  - Accumulators are cleared so a pixel on the very next cycle begins the new frame with no stall.
  - FSM -> COMPUTE.
- FSM:
  - ACCUM: accumulate; end of frame -> COMPUTE.
  - COMPUTE: one cycle; register results from shadow; -> EMIT.
  - EMIT: box_valid = 1 for exactly one cycle; -> ACCUM.
  - Accumulation continues in all states.
  - Back-to-back frames (minimum IMG_WIDTH*IMG_HEIGHT cycles apart) never collide.
- Latency: box_valid is high in the cycle after the second rising edge following the edge that accepts the last pixel.
- Arithmetic, computed in COMPUTE:
  - width = max_x - min_x + 1; height = max_y - min_y + 1.
  - x = (min_x + max_x) >> 1, using an 11-bit sum, truncated (floor).
  - y = (min_y + max_y) >> 1, same rule.
- found = any_set & (pix_cnt >= MIN_PIXELS).
  - If not found: x = y = width = height = 0, box_found = 0.
- Outputs hold their values between pulses.
- Reset mid-frame or mid-COMPUTE/EMIT: everything cleared, no pulse; the first full frame after reset is reported normally.

Optional Feature:
- Macro: BBOX_HOLD_EN.
- Defined: when a frame is not found, x/y/width/height keep the last found values. box_found = 0 and box_valid still pulses, so the overlay does not flicker on dropouts.
- Undefined: not-found frames zero x/y/width/height as specified above.

Test Plan:
- Bench uses IMG_WIDTH=16, IMG_HEIGHT=12, MIN_PIXELS=4.
- Rect mask cols 4..9, rows 3..6 set, contiguous in_valid -> box_valid one pulse 2 edges after pixel (15,11); x=6, y=4, width=6, height=4, box_found=1.
- Frame with 3 set pixels at (0,0), (15,11), (7,5) -> box_found=0, x=y=width=height=0. With BBOX_HOLD_EN, after the previous test: outputs stay 6/4/6/4, box_found=0, box_valid pulses.
- Single set pixel at (15,11) as last pixel with MIN_PIXELS=1 -> x=15, y=11, width=1, height=1. Next frame starting the following cycle, mask at (0,0) only -> x=0, y=0, width=1, height=1; no stall, two separate pulses.
- in_sof asserted at pixel index 50 of a frame -> no box_valid for the aborted partial frame. The next complete frame from that sof reports only its own mask.
- reset asserted during COMPUTE -> box_valid never pulses; all outputs 0; a subsequent full frame reports correctly.
- in_valid toggled 1/0 randomly with the first-scenario mask -> results identical to the first scenario; counters advance only on valid.

Source files
------------

// File: rtl/bbox_if.sv
// Pixel-mask stream in, bounding-box results out, for bbox_extract.
// Stream semantics: a pixel is transferred on every rising clk edge where in_valid
// is high. There is no ready; the sink accepts every pixel. in_sof and in_mask are
// only meaningful while in_valid is high. box_valid is a one-cycle pulse marking
// new x/y/width/height/box_found, which hold until the next pulse.
interface bbox_if;
  logic       in_valid;
  logic       in_sof;
  logic       in_mask;
  logic [9:0] x;
  logic [9:0] y;
  logic [9:0] width;
  logic [9:0] height;
  logic       box_found;
  logic       box_valid;
  logic [1:0] fsm_state;

  modport master (
    output in_valid, in_sof, in_mask,
    input  x, y, width, height, box_found, box_valid, fsm_state
  );

  modport slave (
    input  in_valid, in_sof, in_mask,
    output x, y, width, height, box_found, box_valid, fsm_state
  );
endinterface

// File: rtl/bbox_extract.sv
// Streaming bounding-box extractor over a raster-order 1-bit mask.
// Define BBOX_HOLD_EN to keep the last found box on frames that are not found.
module bbox_extract #(
  parameter int IMG_WIDTH  = 768,
  parameter int IMG_HEIGHT = 576,
  parameter int MIN_PIXELS = 64
) (
  input logic  clk,
  input logic  reset,
  bbox_if.slave bus
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam logic [9:0]  LAST_COL = 10'(IMG_WIDTH - 1);
  localparam logic [9:0]  LAST_ROW = 10'(IMG_HEIGHT - 1);
  localparam logic [19:0] CNT_MAX  = '1;
  localparam logic [19:0] MIN_CNT  = 20'(MIN_PIXELS);

  state_t      state;
  logic [9:0]  col, row;
  logic [9:0]  min_x, max_x, min_y, max_y;
  logic [19:0] pix_cnt;
  logic        any_set;

  logic [9:0]  s_min_x, s_max_x, s_min_y, s_max_y;
  logic [19:0] s_cnt;
  logic        s_any;

  logic [9:0]  r_x, r_y, r_w, r_h;
  logic        r_found;

  logic [9:0]  cur_col, cur_row;
  logic [9:0]  n_min_x, n_max_x, n_min_y, n_max_y;
  logic [19:0] n_cnt;
  logic        n_any;
  logic        eof;
  logic [10:0] sum_x, sum_y;
  logic        found;

  // Next accumulator values with the current pixel folded in; a sof pixel starts
  // from an empty frame so any partial frame before it is dropped.
  always_comb begin
    cur_col = bus.in_sof ? 10'd0 : col;
    cur_row = bus.in_sof ? 10'd0 : row;
    eof     = bus.in_valid && (cur_col == LAST_COL) && (cur_row == LAST_ROW);
    n_any   = bus.in_sof ? 1'b0 : any_set;
    n_cnt   = bus.in_sof ? 20'd0 : pix_cnt;
    n_min_x = min_x;
    n_max_x = max_x;
    n_min_y = min_y;
    n_max_y = max_y;
    if (bus.in_mask) begin
      if (!n_any) begin
        n_min_x = cur_col;
        n_max_x = cur_col;
        n_min_y = cur_row;
        n_max_y = cur_row;
      end else begin
        if (cur_col < n_min_x) n_min_x = cur_col;
        if (cur_col > n_max_x) n_max_x = cur_col;
        if (cur_row < n_min_y) n_min_y = cur_row;
        if (cur_row > n_max_y) n_max_y = cur_row;
      end
      n_any = 1'b1;
      if (n_cnt != CNT_MAX) n_cnt = n_cnt + 20'd1;
    end
    sum_x = {1'b0, s_min_x} + {1'b0, s_max_x};
    sum_y = {1'b0, s_min_y} + {1'b0, s_max_y};
    found = s_any && (s_cnt >= MIN_CNT);
  end

  assign bus.fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ACCUM;
      col           <= '0;
      row           <= '0;
      min_x         <= '0;
      max_x         <= '0;
      min_y         <= '0;
      max_y         <= '0;
      pix_cnt       <= '0;
      any_set       <= 1'b0;
      s_min_x       <= '0;
      s_max_x       <= '0;
      s_min_y       <= '0;
      s_max_y       <= '0;
      s_cnt         <= '0;
      s_any         <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_w           <= '0;
      r_h           <= '0;
      r_found       <= 1'b0;
      bus.x         <= '0;
      bus.y         <= '0;
      bus.width     <= '0;
      bus.height    <= '0;
      bus.box_found <= 1'b0;
      bus.box_valid <= 1'b0;
    end else begin
      bus.box_valid <= 1'b0;

      if (bus.in_valid) begin
        if (cur_col == LAST_COL) begin
          col <= '0;
          row <= (cur_row == LAST_ROW) ? 10'd0 : cur_row + 10'd1;
        end else begin
          col <= cur_col + 10'd1;
          row <= cur_row;
        end
        if (eof) begin
          // Snapshot the finished frame and start the next one on the very next pixel.
          s_min_x <= n_min_x;
          s_max_x <= n_max_x;
          s_min_y <= n_min_y;
          s_max_y <= n_max_y;
          s_cnt   <= n_cnt;
          s_any   <= n_any;
          min_x   <= '0;
          max_x   <= '0;
          min_y   <= '0;
          max_y   <= '0;
          pix_cnt <= '0;
          any_set <= 1'b0;
        end else begin
          min_x   <= n_min_x;
          max_x   <= n_max_x;
          min_y   <= n_min_y;
          max_y   <= n_max_y;
          pix_cnt <= n_cnt;
          any_set <= n_any;
        end
      end

      case (state)
        COMPUTE: begin
          if (found) begin
            r_x     <= sum_x[10:1];
            r_y     <= sum_y[10:1];
            r_w     <= s_max_x - s_min_x + 10'd1;
            r_h     <= s_max_y - s_min_y + 10'd1;
            r_found <= 1'b1;
          end else begin
            r_found <= 1'b0;
`ifdef BBOX_HOLD_EN
            r_x     <= r_x;
`else
            r_x     <= '0;
            r_y     <= '0;
            r_w     <= '0;
            r_h     <= '0;
`endif
          end
          state <= EMIT;
        end
        EMIT: begin
          bus.x         <= r_x;
          bus.y         <= r_y;
          bus.width     <= r_w;
          bus.height    <= r_h;
          bus.box_found <= r_found;
          bus.box_valid <= 1'b1;
          state         <= ACCUM;
        end
        default: state <= ACCUM;
      endcase

      if (eof) state <= COMPUTE;
    end
  end

endmodule

// File: tb/tb_bbox_extract.sv
// Bench for bbox_extract: two instances (MIN_PIXELS 4 and 1) share one mask stream
// and are checked against a frame-level model through per-instance expected queues.
module tb_bbox_extract;
  localparam int W    = 16;
  localparam int H    = 12;
  localparam int NPIX = W * H;
`ifdef BBOX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] due;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  w;
    logic [9:0]  h;
    logic        f;
  } exp_t;

  typedef struct {
    int c0, c1, r0, r1;
    int ex, ey, ew, eh;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic in_valid = 1'b0;
  logic in_sof   = 1'b0;
  logic in_mask  = 1'b0;

  bbox_if ifa ();
  bbox_if ifb ();

  assign ifa.in_valid = in_valid;
  assign ifa.in_sof   = in_sof;
  assign ifa.in_mask  = in_mask;
  assign ifb.in_valid = in_valid;
  assign ifb.in_sof   = in_sof;
  assign ifb.in_mask  = in_mask;

  bbox_extract #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_PIXELS(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );
  bbox_extract #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_PIXELS(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  logic       bv [2];
  logic       of [2];
  logic [9:0] ox [2];
  logic [9:0] oy [2];
  logic [9:0] ow [2];
  logic [9:0] oh [2];
  assign bv[0] = ifa.box_valid;  assign bv[1] = ifb.box_valid;
  assign of[0] = ifa.box_found;  assign of[1] = ifb.box_found;
  assign ox[0] = ifa.x;          assign ox[1] = ifb.x;
  assign oy[0] = ifa.y;          assign oy[1] = ifb.y;
  assign ow[0] = ifa.width;      assign ow[1] = ifb.width;
  assign oh[0] = ifa.height;     assign oh[1] = ifb.height;

  // ---------------- scoreboard state ----------------
  exp_t  exp_q [2][$];
  exp_t  last_found [2];
  bit    mask [H][W];
  string dn [2] = '{"a", "b"};
  int    n_vec = 0;
  int    n_err = 0;
  vec_t  tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: box straight from the stored mask picture.
  function automatic exp_t model_box(input int minp, input int due, input exp_t last);
    exp_t e;
    int mnx = W, mxx = -1, mny = H, mxy = -1, cnt = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (mask[r][c]) begin
          cnt++;
          if (c < mnx) mnx = c;
          if (c > mxx) mxx = c;
          if (r < mny) mny = r;
          if (r > mxy) mxy = r;
        end
    e     = '0;
    e.due = due;
    if (cnt > 0 && cnt >= minp) begin
      e.f = 1'b1;
      e.x = 10'((mnx + mxx) / 2);
      e.y = 10'((mny + mxy) / 2);
      e.w = 10'(mxx - mnx + 1);
      e.h = 10'(mxy - mny + 1);
    end else begin
      e.x = HOLD ? last.x : 10'd0;
      e.y = HOLD ? last.y : 10'd0;
      e.w = HOLD ? last.w : 10'd0;
      e.h = HOLD ? last.h : 10'd0;
    end
    return e;
  endfunction

  task automatic push_model(input int due);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      e = model_box((d == 0) ? 4 : 1, due, last_found[d]);
      if (e.f) last_found[d] = e;
      exp_q[d].push_back(e);
    end
  endtask

  task automatic push_const(input int due, input int x, input int y, input int w, input int h);
    exp_t e;
    e     = '0;
    e.due = due;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.w   = 10'(w);
    e.h   = 10'(h);
    e.f   = 1'b1;
    for (int d = 0; d < 2; d++) begin
      last_found[d] = e;
      exp_q[d].push_back(e);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    if (bv[d]) begin
      if (exp_q[d].size() == 0) begin
        chk($sformatf("%s.unexpected_pulse", dn[d]), int'(bv[d]), 0);
      end else begin
        e = exp_q[d].pop_front();
        chk($sformatf("%s.pulse_cycle", dn[d]), cyc, int'(e.due));
        chk($sformatf("%s.x", dn[d]), int'(ox[d]), int'(e.x));
        chk($sformatf("%s.y", dn[d]), int'(oy[d]), int'(e.y));
        chk($sformatf("%s.width", dn[d]), int'(ow[d]), int'(e.w));
        chk($sformatf("%s.height", dn[d]), int'(oh[d]), int'(e.h));
        chk($sformatf("%s.box_found", dn[d]), int'(of[d]), int'(e.f));
      end
    end else if (exp_q[d].size() > 0 && int'(exp_q[d][0].due) < cyc) begin
      e = exp_q[d].pop_front();
      chk($sformatf("%s.missing_pulse", dn[d]), int'(bv[d]), 1);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.%s.x", tag, dn[d]), int'(ox[d]), 0);
      chk($sformatf("%s.%s.y", tag, dn[d]), int'(oy[d]), 0);
      chk($sformatf("%s.%s.width", tag, dn[d]), int'(ow[d]), 0);
      chk($sformatf("%s.%s.height", tag, dn[d]), int'(oh[d]), 0);
      chk($sformatf("%s.%s.box_found", tag, dn[d]), int'(of[d]), 0);
      chk($sformatf("%s.%s.box_valid", tag, dn[d]), int'(bv[d]), 0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic s, input logic m);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_mask  = m;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  task automatic send_frame(input int npix, input int gap_pct, output int last_cyc);
    last_cyc = cyc;
    for (int i = 0; i < npix; i++) begin
      while (int'($urandom_range(99)) < gap_pct)
        drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      drive(1'b1, i == 0, mask[i / W][i % W]);
      last_cyc = cyc;
    end
  endtask

  // Last pixel is driven in cycle c, accepted on the edge that makes cyc c+1,
  // and box_valid is seen two edges later.
  task automatic full_frame(input int gap_pct);
    int lc;
    send_frame(NPIX, gap_pct, lc);
    push_model(lc + 3);
  endtask

  task automatic clear_mask();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        mask[r][c] = 1'b0;
  endtask

  task automatic set_rect(input int c0, input int c1, input int r0, input int r1);
    clear_mask();
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++)
        mask[r][c] = 1'b1;
  endtask

  // ---------------- test ----------------
  initial begin
    int lc;
    int dens;
    tbl[0] = '{4, 9, 3, 6, 6, 4, 6, 4};
    tbl[1] = '{0, 15, 0, 11, 7, 5, 16, 12};
    tbl[2] = '{0, 1, 0, 1, 0, 0, 2, 2};
    tbl[3] = '{14, 15, 10, 11, 14, 10, 2, 2};
    tbl[4] = '{3, 10, 5, 5, 6, 5, 8, 1};
    tbl[5] = '{7, 7, 0, 11, 7, 5, 1, 12};
    last_found[0] = '0;
    last_found[1] = '0;
    clear_mask();

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          mon(0);
          mon(1);
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    idle(3);

    // Table rectangles, streamed back to back.
    for (int i = 0; i < 6; i++) begin
      set_rect(tbl[i].c0, tbl[i].c1, tbl[i].r0, tbl[i].r1);
      send_frame(NPIX, 0, lc);
      push_const(lc + 3, tbl[i].ex, tbl[i].ey, tbl[i].ew, tbl[i].eh);
    end
    idle(6);

    // First rectangle with in_valid randomly gapped.
    set_rect(4, 9, 3, 6);
    full_frame(50);
    idle(6);

    // Three set pixels: below MIN_PIXELS for a, found for b.
    clear_mask();
    mask[0][0]   = 1'b1;
    mask[11][15] = 1'b1;
    mask[5][7]   = 1'b1;
    full_frame(0);
    idle(6);

    // Single pixel at the last position, then a frame starting the very next cycle.
    clear_mask();
    mask[11][15] = 1'b1;
    full_frame(0);
    clear_mask();
    mask[0][0] = 1'b1;
    full_frame(0);
    idle(6);

    // Sof at pixel index 50 aborts the partial frame.
    set_rect(0, 15, 0, 3);
    send_frame(50, 0, lc);
    set_rect(10, 12, 8, 9);
    full_frame(0);
    idle(6);

    // Reset while the finished frame is in COMPUTE.
    set_rect(4, 9, 3, 6);
    send_frame(NPIX, 0, lc);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    last_found[0] = '0;
    last_found[1] = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset_compute");
    reset = 1'b0;
    idle(8);
    set_rect(3, 10, 5, 5);
    full_frame(0);
    idle(6);

    // Random masks of varying density and random valid gaps.
    for (int k = 0; k < 6; k++) begin
      case (k % 4)
        0: dens = 1;
        1: dens = 3;
        2: dens = 15;
        default: dens = 40;
      endcase
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          mask[r][c] = (int'($urandom_range(99)) < dens);
      full_frame(int'($urandom_range(40)));
    end

    idle(10);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s.drained", dn[d]), exp_q[d].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
